counter_monitor: RTL and testbench

Passive observer for the 4-bit up/down counter. It samples the counter value every enabled clock and classifies each step as hold, up, down or illegal. It reports the current direction, one-cycle wrap and error pulses, and a saturating error count. It sits beside the counter in benches and in integrated designs as an on-line protocol checker.

---
 rtl/counter_mon_pkg.sv | 18 +
 rtl/counter_step_classifier.sv | 38 +++
 rtl/counter_monitor.sv | 133 +++++++++++++
 tb/tb_counter_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// Shared encodings for the counter monitor: observer state and step class.
package counter_mon_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    HOLD   = 2'd1,
    UP     = 2'd2,
    DOWN   = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

endpackage

// File: rtl/counter_step_classifier.sv
// Combinational classifier: turns the modular difference between two counter
// samples into a step class and flags the two wrap-around transitions.
module counter_step_classifier
  import counter_mon_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] counter_in,
  output step_t            step,
  output logic             is_wrap_up,
  output logic             is_wrap_down
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] delta;

  // Natural WIDTH-bit wrap makes max->0 a +1 step and 0->max a -1 step.
  assign delta = counter_in - prev;

  always_comb begin
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == ONE) begin
      step = STEP_UP;
    end else if (delta == MAX) begin
      step = STEP_DOWN;
    end else begin
      step = STEP_ILLEGAL;
    end
  end

  assign is_wrap_up   = (prev == MAX) && (counter_in == '0);
  assign is_wrap_down = (prev == '0) && (counter_in == MAX);

endmodule

// File: rtl/counter_monitor.sv
// Passive on-line checker for an up/down counter: tracks direction, flags
// wraps and illegal steps, and keeps a saturating count of the latter.
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sample_en,
  input  logic                 sync_clear,
  input  logic [WIDTH-1:0]     counter_in,
  output logic                 dir_valid,
  output logic                 direction,
  output logic                 holding,
  output logic                 wrap_up,
  output logic                 wrap_down,
  output logic                 error_pulse,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  mon_state_t           state_reg, state_next;
  logic [WIDTH-1:0]     prev_reg, prev_next;
  logic                 direction_reg, direction_next;
  logic                 wrap_up_reg, wrap_up_next;
  logic                 wrap_down_reg, wrap_down_next;
  logic                 error_pulse_reg, error_pulse_next;
  logic [ERR_CNT_W-1:0] error_count_reg, error_count_next;

  step_t step;
  logic  is_wrap_up;
  logic  is_wrap_down;
  logic  sample_ok;
  logic  tracking;

  counter_step_classifier #(
    .WIDTH(WIDTH)
  ) u_classifier (
    .prev        (prev_reg),
    .counter_in  (counter_in),
    .step        (step),
    .is_wrap_up  (is_wrap_up),
    .is_wrap_down(is_wrap_down)
  );

  // sync_clear outranks sample_en; a step only counts once we hold a valid prev.
  assign sample_ok = sample_en && !sync_clear;
  assign tracking  = sample_ok && (state_reg != UNSYNC);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= UNSYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = UNSYNC;
    if (sample_ok) begin
      if (state_reg == UNSYNC) begin
        state_next = HOLD;
      end else begin
        unique case (step)
          STEP_UP:   state_next = UP;
          STEP_DOWN: state_next = DOWN;
          default:   state_next = HOLD;
        endcase
      end
    end
  end

  always_comb begin
    prev_next        = prev_reg;
    direction_next   = direction_reg;
    wrap_up_next     = 1'b0;
    wrap_down_next   = 1'b0;
    error_pulse_next = 1'b0;
    error_count_next = error_count_reg;
    if (sample_ok) begin
      prev_next = counter_in;
    end
    if (tracking) begin
      unique case (step)
        STEP_UP: begin
          direction_next = 1'b1;
          wrap_up_next   = is_wrap_up;
        end
        STEP_DOWN: begin
          direction_next = 1'b0;
          wrap_down_next = is_wrap_down;
        end
        STEP_ILLEGAL: begin
          error_pulse_next = 1'b1;
          if (error_count_reg != ERR_MAX) begin
            error_count_next = error_count_reg + ERR_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg        <= '0;
      direction_reg   <= 1'b0;
      wrap_up_reg     <= 1'b0;
      wrap_down_reg   <= 1'b0;
      error_pulse_reg <= 1'b0;
      error_count_reg <= '0;
    end else begin
      prev_reg        <= prev_next;
      direction_reg   <= direction_next;
      wrap_up_reg     <= wrap_up_next;
      wrap_down_reg   <= wrap_down_next;
      error_pulse_reg <= error_pulse_next;
      error_count_reg <= error_count_next;
    end
  end

  assign dir_valid   = (state_reg == UP) || (state_reg == DOWN);
  assign holding     = (state_reg == HOLD);
  assign direction   = direction_reg;
  assign wrap_up     = wrap_up_reg;
  assign wrap_down   = wrap_down_reg;
  assign error_pulse = error_pulse_reg;
  assign error_count = error_count_reg;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor (ERR_CNT_W=2 so saturation is reachable);
// observed outputs are packed as {dir_valid,direction,holding,wrap_up,wrap_down,error_pulse,error_count}.
module tb_counter_monitor;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       sample_en = 1'b0;
  logic       sync_clear = 1'b0;
  logic [3:0] counter_in = 4'd0;
  logic       dir_valid, direction, holding, wrap_up, wrap_down, error_pulse;
  logic [1:0] error_count;
  logic [7:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  counter_monitor #(
    .WIDTH    (4),
    .ERR_CNT_W(2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .sync_clear (sync_clear),
    .counter_in (counter_in),
    .dir_valid  (dir_valid),
    .direction  (direction),
    .holding    (holding),
    .wrap_up    (wrap_up),
    .wrap_down  (wrap_down),
    .error_pulse(error_pulse),
    .error_count(error_count)
  );

  assign obs = {dir_valid, direction, holding, wrap_up, wrap_down, error_pulse, error_count};

  // Drive one cycle of stimulus and land 1 time unit after the sampling edge.
  task automatic drive(input logic se, input logic sc, input logic [3:0] val);
    sample_en  = se;
    sync_clear = sc;
    counter_in = val;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    sample_en  = 1'b0;
    sync_clear = 1'b0;
    reset_n    = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    reset_n    = 1'b0;
    counter_in = 4'd5;
    sample_en  = 1'b1;
    #1;
    vectors++;
    if (obs !== 8'b0000_0000) begin
      miscompares++;
      $display("FAIL reset_async: got %b expected %b", obs, 8'b0);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (obs !== 8'b0000_0000) begin
      miscompares++;
      $display("FAIL reset_held: got %b expected %b", obs, 8'b0);
    end
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 4'd5);
    $display("reset: in=5 obs=%b", obs);
    vectors++;
    if (obs !== 8'b0010_0000) begin
      miscompares++;
      $display("FAIL reset_first_sample: got %b expected %b", obs, 8'b0010_0000);
    end
  endtask

  task automatic test_up_run();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b0, 4'(i % 16));
      if (i == 0) exp = 8'b0010_0000;
      else if (i == 16) exp = 8'b1101_0000;
      else exp = 8'b1100_0000;
      $display("up_run[%0d]: in=%0d obs=%b exp=%b", i, i % 16, obs, exp);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL up_run[%0d]: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_down_run();
    logic [3:0] vals [6] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    logic [7:0] exps [6] = '{8'b0010_0000, 8'b1000_0000, 8'b1000_0000,
                             8'b1000_0000, 8'b1000_1000, 8'b1000_0000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      $display("down_run[%0d]: in=%0d obs=%b exp=%b", i, vals[i], obs, exps[i]);
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL down_run[%0d]: got %b expected %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_hold_illegal();
    logic [3:0] vals [6] = '{4'd6, 4'd7, 4'd7, 4'd7, 4'd11, 4'd12};
    logic [7:0] exps [6] = '{8'b0010_0000, 8'b1100_0000, 8'b0110_0000,
                             8'b0110_0000, 8'b0110_0101, 8'b1100_0001};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      $display("hold_illegal[%0d]: in=%0d obs=%b exp=%b", i, vals[i], obs, exps[i]);
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL hold_illegal[%0d]: got %b expected %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] vals [6] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0, 4'd4};
    logic [7:0] exps [6] = '{8'b0010_0000, 8'b0010_0101, 8'b0010_0110,
                             8'b0010_0111, 8'b0010_0111, 8'b0010_0111};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      $display("saturation[%0d]: in=%0d obs=%b exp=%b", i, vals[i], obs, exps[i]);
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got %b expected %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_idle_resume();
    logic       ses  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] vals [5] = '{4'd4, 4'd5, 4'd9, 4'd9, 4'd10};
    logic [7:0] exps [5] = '{8'b0010_0000, 8'b1100_0000, 8'b0100_0000,
                             8'b0110_0000, 8'b1100_0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(ses[i], 1'b0, vals[i]);
      $display("idle_resume[%0d]: se=%0b in=%0d obs=%b exp=%b", i, ses[i], vals[i], obs, exps[i]);
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL idle_resume[%0d]: got %b expected %b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_mid_run_reset();
    logic       scs  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] vals [6] = '{4'd9, 4'd10, 4'd0, 4'd0, 4'd1, 4'd2};
    logic [7:0] exps [6] = '{8'b0010_0000, 8'b1100_0000, 8'b0100_0000,
                             8'b0110_0000, 8'b1100_0000, 8'b1100_0000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, scs[i], vals[i]);
      $display("mid_run[%0d]: sc=%0b in=%0d obs=%b exp=%b", i, scs[i], vals[i], obs, exps[i]);
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL mid_run[%0d]: got %b expected %b", i, obs, exps[i]);
      end
    end
    // Make an error count non-zero first so the async clear has something to clear.
    drive(1'b1, 1'b0, 4'd8);
    vectors++;
    if (obs !== 8'b0110_0101) begin
      miscompares++;
      $display("FAIL mid_run_err: got %b expected %b", obs, 8'b0110_0101);
    end
    #2;
    reset_n = 1'b0;
    #1;
    $display("mid_run_async_reset: obs=%b exp=%b", obs, 8'b0);
    vectors++;
    if (obs !== 8'b0000_0000) begin
      miscompares++;
      $display("FAIL mid_run_async_reset: got %b expected %b", obs, 8'b0);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_run();
    test_down_run();
    test_hold_illegal();
    test_saturation();
    test_idle_resume();
    test_mid_run_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
